// File: rtl/io_mux.sv
// Single-pin I/O function mux: routes one pad to one of RXCOUNT receive or TXCOUNT transmit functions.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none, the outputs follow the inputs every cycle.
module io_mux #(
    parameter  int RXCOUNT = 1,
    parameter  int TXCOUNT = 1,
    localparam int FCOUNT  = RXCOUNT + TXCOUNT,
    localparam int FWIDTH  = $clog2(FCOUNT)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pin_ena,
    output logic               pin_out,
    input  logic               pin_in,
    input  logic [FWIDTH-1:0]  func_select,
    input  logic [TXCOUNT-1:0] func_transmit,
    output logic [RXCOUNT-1:0] func_receive
);

    // Limits carry one extra bit because FCOUNT itself may equal 2**FWIDTH.
    localparam logic [FWIDTH:0]   RX_LIM  = (FWIDTH+1)'(RXCOUNT);
    localparam logic [FWIDTH:0]   F_LIM   = (FWIDTH+1)'(FCOUNT);
    localparam logic [FWIDTH-1:0] RX_BASE = FWIDTH'(RXCOUNT);

    logic [FWIDTH:0]    sel_ext;
    logic [FWIDTH-1:0]  tx_idx;
    logic               ena_nxt;
    logic               out_nxt;
    logic [RXCOUNT-1:0] rx_nxt;

    assign sel_ext = {1'b0, func_select};

    always_comb begin
        ena_nxt = 1'b0;
        out_nxt = 1'b0;
        rx_nxt  = '0;
        tx_idx  = func_select - RX_BASE;
        if (sel_ext < RX_LIM) begin
            for (int k = 0; k < RXCOUNT; k++) begin
                if (func_select == FWIDTH'(k)) begin
                    rx_nxt[k] = pin_in;
                end
            end
        end else if (sel_ext < F_LIM) begin
            ena_nxt = 1'b1;
            for (int k = 0; k < TXCOUNT; k++) begin
                if (tx_idx == FWIDTH'(k)) begin
                    out_nxt = func_transmit[k];
                end
            end
        end
        // Selects at or beyond FCOUNT fall through as idle: pad released, nothing received.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pin_ena      <= 1'b0;
            pin_out      <= 1'b0;
            func_receive <= '0;
        end else begin
            pin_ena      <= ena_nxt;
            pin_out      <= out_nxt;
            func_receive <= rx_nxt;
        end
    end

endmodule

// File: tb/tb_io_mux.sv
// Directed bench for io_mux across several RXCOUNT/TXCOUNT configurations.
module tb_io_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // RX=2, TX=2
    logic       ena22, out22, pin22;
    logic [1:0] sel22, tx22, rx22;
    // RX=2, TX=1 (FCOUNT=3, select 3 is out of range)
    logic       ena21, out21, pin21;
    logic [1:0] sel21, rx21;
    logic [0:0] tx21;
    // RX=1, TX=1
    logic       ena11, out11, pin11;
    logic [0:0] sel11, tx11, rx11;
    // RX=3, TX=3 (FCOUNT=6, selects 6 and 7 out of range)
    logic       ena33, out33, pin33;
    logic [2:0] sel33, tx33, rx33;

    io_mux #(.RXCOUNT(2), .TXCOUNT(2)) u22 (
        .clk(clk), .rst(rst), .pin_ena(ena22), .pin_out(out22), .pin_in(pin22),
        .func_select(sel22), .func_transmit(tx22), .func_receive(rx22));
    io_mux #(.RXCOUNT(2), .TXCOUNT(1)) u21 (
        .clk(clk), .rst(rst), .pin_ena(ena21), .pin_out(out21), .pin_in(pin21),
        .func_select(sel21), .func_transmit(tx21), .func_receive(rx21));
    io_mux #(.RXCOUNT(1), .TXCOUNT(1)) u11 (
        .clk(clk), .rst(rst), .pin_ena(ena11), .pin_out(out11), .pin_in(pin11),
        .func_select(sel11), .func_transmit(tx11), .func_receive(rx11));
    io_mux #(.RXCOUNT(3), .TXCOUNT(3)) u33 (
        .clk(clk), .rst(rst), .pin_ena(ena33), .pin_out(out33), .pin_in(pin33),
        .func_select(sel33), .func_transmit(tx33), .func_receive(rx33));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] txv;
        logic       exp_ena, exp_out;
        logic [2:0] exp_rx;

        sel22 = 2'd2; tx22 = 2'b11; pin22 = 1'b0;
        sel21 = 2'd0; tx21 = 1'b0;  pin21 = 1'b1;
        sel11 = 1'd1; tx11 = 1'b1;  pin11 = 1'b0;
        sel33 = 3'd0; tx33 = 3'd0;  pin33 = 1'b1;

        // Reset dominates whatever the inputs select
        rst = 1'b1;
        tick();
        check("rst_ena22", ena22, 0);
        check("rst_out22", out22, 0);
        check("rst_rx22",  rx22,  0);
        check("rst_rx21",  rx21,  0);
        check("rst_ena11", ena11, 0);
        check("rst_rx33",  rx33,  0);

        rst = 1'b0;
        tick();
        check("post_rst_ena22", ena22, 1);
        check("post_rst_out22", out22, 1);
        check("post_rst_rx22",  rx22,  0);
        check("post_rst_rx21",  rx21,  2'b01);

        // Out-of-range select on a 3-function mux is idle
        sel21 = 2'd3; tx21 = 1'b1; pin21 = 1'b1;
        tick();
        check("oor_ena21", ena21, 0);
        check("oor_out21", out21, 0);
        check("oor_rx21",  rx21,  0);
        sel21 = 2'd2;
        tick();
        check("tx_ena21", ena21, 1);
        check("tx_out21", out21, 1);
        sel21 = 2'd1;
        tick();
        check("rx1_ena21", ena21, 0);
        check("rx1_rx21",  rx21,  2'b10);

        // Receive functions ignore the transmit bus
        sel22 = 2'd1; pin22 = 1'b1; tx22 = 2'b11;
        tick();
        check("rx1_ena22", ena22, 0);
        check("rx1_out22", out22, 0);
        check("rx1_rx22",  rx22,  2'b10);
        sel22 = 2'd0;
        tick();
        check("rx0_rx22", rx22, 2'b01);
        sel22 = 2'd3; tx22 = 2'b01;
        tick();
        check("tx1_lo_out22", out22, 0);
        check("tx1_lo_rx22",  rx22,  0);
        tx22 = 2'b10;
        tick();
        check("tx1_hi_out22", out22, 1);

        // Switch from receive to transmit: unchanged until the edge, then all at once
        sel11 = 1'd0; pin11 = 1'b1; tx11 = 1'b0;
        tick();
        check("sw_rx_rx11",  rx11,  1);
        check("sw_rx_ena11", ena11, 0);
        sel11 = 1'd1; tx11 = 1'b1;
        #2;
        check("sw_hold_rx11",  rx11,  1);
        check("sw_hold_ena11", ena11, 0);
        tick();
        check("sw_tx_ena11", ena11, 1);
        check("sw_tx_out11", out11, 1);
        check("sw_tx_rx11",  rx11,  0);

        // Mid-operation reset with inputs held
        rst = 1'b1;
        tick();
        check("midrst_ena11", ena11, 0);
        check("midrst_out11", out11, 0);
        rst = 1'b0;
        tick();
        check("midrst_rel_ena11", ena11, 1);
        check("midrst_rel_out11", out11, 1);

        // Full select/transmit/pin sweep on the 3+3 mux, including out-of-range 6 and 7
        for (int s = 0; s < 8; s++) begin
            for (int t = 0; t < 8; t++) begin
                for (int p = 0; p < 2; p++) begin
                    sel33 = 3'(s); tx33 = 3'(t); pin33 = p[0];
                    tick();
                    txv = 3'(t);
                    exp_ena = 1'b0; exp_out = 1'b0; exp_rx = 3'b000;
                    if (s < 3) begin
                        exp_rx = 3'(p << s);
                    end else if (s < 6) begin
                        exp_ena = 1'b1;
                        exp_out = txv[s-3];
                    end
                    check($sformatf("sw33_ena s%0d t%0d p%0d", s, t, p), ena33, exp_ena);
                    check($sformatf("sw33_out s%0d t%0d p%0d", s, t, p), out33, exp_out);
                    check($sformatf("sw33_rx s%0d t%0d p%0d", s, t, p),  rx33,  exp_rx);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/io_mux.md
# io_mux

Registered single-pin I/O function multiplexer. It connects one physical bidirectional pin to one of RXCOUNT receive functions or TXCOUNT transmit functions, chosen by a binary function selector. It sits between the pad/tristate buffer (pin_ena, pin_out, pin_in) and the peripheral logic that owns the individual functions. All outputs are registered on one clock with synchronous active-high reset.

## Interface
Parameters:
- RXCOUNT, default 1: number of receive (input) functions; must be ≥1.
- TXCOUNT, default 1: number of transmit (output) functions; must be ≥1.
- FCOUNT (local): RXCOUNT+TXCOUNT.
- FWIDTH (local): $clog2(FCOUNT); always ≥1 because FCOUNT ≥2.

Ports (in this order):
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pin_ena  output  1  tristate output-enable for the pad; 1 drives the pin.
- pin_out  output  1  value driven to the pad when pin_ena=1.
- pin_in  input  1  value read back from the pad.
- func_select  input  FWIDTH  function index; 0..RXCOUNT-1 select receive functions, RXCOUNT..FCOUNT-1 select transmit functions.
- func_transmit  input  TXCOUNT  per-function transmit values; bit k belongs to transmit function k (select RXCOUNT+k).
- func_receive  output  RXCOUNT  per-function received values; bit k belongs to receive function k (select k).

## Operation
- Receive mode (func_select < RXCOUNT):
  - pin_ena = 0, pin_out = 0.
  - func_receive[func_select] = pin_in; every other func_receive bit = 0.
  - func_transmit is ignored entirely.
- Transmit mode (RXCOUNT ≤ func_select < FCOUNT):
  - pin_ena = 1.
  - pin_out = func_transmit[func_select − RXCOUNT].
  - func_receive = all zeros regardless of pin_in.
  - Unselected func_transmit bits have no effect on any output.
- Out-of-range select (func_select ≥ FCOUNT, possible when FCOUNT is not a power of two): treated as idle: pin_ena = 0, pin_out = 0, func_receive = 0.
- pin_out is never 1 while pin_ena is 0.
- At most one func_receive bit is ever 1.
- Index arithmetic (func_select − RXCOUNT) is computed at FWIDTH bits. It is only used when func_select ≥ RXCOUNT, so it cannot underflow.

## Timing
- The next-state values of pin_ena, pin_out and func_receive are combinational functions of the current func_select, func_transmit and pin_in. These values are captured into output registers on each rising clk edge.
- Latency: 1 cycle from any input change to the corresponding output change. There is no handshake.
- A func_select change takes effect in one edge. No intermediate state is produced in which pin_ena=1 together with a receive-mode func_receive value.
- Reset (rst=1 at a rising edge): pin_ena=0, pin_out=0, func_receive=0 on the following cycle, regardless of other inputs. This also applies mid-operation.
- After rst deasserts, the first edge loads normal function values.
- pin_in is sampled only by the output register. The integrator is responsible for any metastability synchronizer.

## Test plan
- Reset: RXCOUNT=2, TXCOUNT=2, func_select=2, func_transmit=2'b11, rst=1 for one edge -> pin_ena=0, pin_out=0, func_receive=2'b00. Release rst -> next edge pin_ena=1, pin_out=1.
- Receive sweep: for every RXCOUNT,TXCOUNT in 1..8, every select s<RXCOUNT, every func_transmit in 0..2^TXCOUNT−1 and every pin_in in {0,1} -> after one edge pin_ena=0, pin_out=0, func_receive = pin_in<<s.
- Transmit sweep: same parameter grid, every select s in RXCOUNT..FCOUNT−1, all func_transmit and pin_in values -> pin_ena=1, pin_out=func_transmit[s−RXCOUNT], func_receive=0.
- Out-of-range select: RXCOUNT=2, TXCOUNT=1, func_select=3, func_transmit=1, pin_in=1 -> pin_ena=0, pin_out=0, func_receive=0.
- Switch and latency: RXCOUNT=1, TXCOUNT=1. Hold func_select=0, pin_in=1 (func_receive=1). Then change to func_select=1, func_transmit=1 -> outputs unchanged until the next edge. After that edge pin_ena=1, pin_out=1, func_receive=0 in the same cycle.
- Mid-operation reset: transmitting with pin_out=1, assert rst for one edge -> pin_ena and pin_out go to 0 on that edge even though inputs are unchanged.
